// File: rtl/rx_session_ctrl.sv
// ---------------------------------------------------------------------------
// rx_session_ctrl
//
// Session controller for an AXI-Stream receive path. A session is opened by
// i_start from IDLE. In RECV the transport block is told to receive
// (o_rx_rcving) and every upstream handshake is counted. The session closes on
// the highest-priority terminating event: abort, transport done, beat limit
// or (optionally) idle timeout. DONE lasts one cycle and then returns to IDLE.
// The completion code and beat count are held until the next start.
//
// Optional feature: define RX_TIMEOUT_EN to compile in the idle-timeout
// counter and the i_timeout_cycles port. Without it, status 2'b10 never occurs.
//
// Parameters
//   CNT_W             width of the beat counter, beat limit and timeout limit
//
// Ports
//   s_axis_aclk       clock, rising edge
//   s_axis_aresetn    asynchronous active-low reset
//   i_start           one-cycle session start request (IDLE only)
//   i_abort           one-cycle abort request (RECV only)
//   i_max_beats       beat limit, 0 = unlimited, sampled at start
//   i_timeout_cycles  idle-cycle limit, 0 = disabled, sampled at start
//                     (RX_TIMEOUT_EN builds only)
//   i_hsked           upstream beat handshake (tvalid & tready)
//   i_rx_done         end-of-session pulse from the transport block
//   o_rx_rcving       receive enable, high in RECV
//   o_busy            high in any state except IDLE
//   o_done            one-cycle completion pulse (DONE state)
//   o_status          00 ok, 01 beat limit, 10 timeout, 11 abort
//   o_beat_count      beats accepted in the current or last session
// ---------------------------------------------------------------------------
module rx_session_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_aresetn,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_max_beats,
`ifdef RX_TIMEOUT_EN
    input  logic [CNT_W-1:0] i_timeout_cycles,
`endif
    input  logic             i_hsked,
    input  logic             i_rx_done,
    output logic             o_rx_rcving,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic [CNT_W-1:0] o_beat_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       STATUS_OK      = 2'b00;
    localparam logic [1:0]       STATUS_LIMIT   = 2'b01;
    localparam logic [1:0]       STATUS_TIMEOUT = 2'b10;
    localparam logic [1:0]       STATUS_ABORT   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ZERO       = '0;
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX        = '1;

    state_t           state_reg,     state_next;
    logic [CNT_W-1:0] beat_cnt_reg,  beat_cnt_next;
    logic [1:0]       status_reg,    status_next;
    logic [CNT_W-1:0] max_beats_reg, max_beats_next;
    logic [CNT_W-1:0] beat_inc;
    logic             limit_hit;
    logic             timeout_hit;

`ifdef RX_TIMEOUT_EN
    logic [CNT_W-1:0] timeout_reg,  timeout_next;
    logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic [CNT_W-1:0] idle_inc;
`endif

    // Saturating increment of the beat counter.
    assign beat_inc = (beat_cnt_reg == CNT_MAX) ? beat_cnt_reg : beat_cnt_reg + CNT_ONE;

    // The limit is checked against the post-handshake count so the session
    // closes on the very beat that reaches it.
    assign limit_hit = (max_beats_reg != CNT_ZERO) && i_hsked && (beat_inc == max_beats_reg);

`ifdef RX_TIMEOUT_EN
    assign idle_inc = (idle_cnt_reg == CNT_MAX) ? idle_cnt_reg : idle_cnt_reg + CNT_ONE;
    // Fires on the Nth consecutive idle RECV cycle, so DONE follows exactly
    // N idle cycles after the last handshake.
    assign timeout_hit = (timeout_reg != CNT_ZERO) && !i_hsked && (idle_inc == timeout_reg);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_reg     <= ST_IDLE;
            beat_cnt_reg  <= '0;
            status_reg    <= STATUS_OK;
            max_beats_reg <= '0;
`ifdef RX_TIMEOUT_EN
            timeout_reg   <= '0;
            idle_cnt_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            status_reg    <= status_next;
            max_beats_reg <= max_beats_next;
`ifdef RX_TIMEOUT_EN
            timeout_reg   <= timeout_next;
            idle_cnt_reg  <= idle_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        status_next    = status_reg;
        max_beats_next = max_beats_reg;
`ifdef RX_TIMEOUT_EN
        timeout_next   = timeout_reg;
        idle_cnt_next  = idle_cnt_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    max_beats_next = i_max_beats;
                    beat_cnt_next  = '0;
                    status_next    = STATUS_OK;
`ifdef RX_TIMEOUT_EN
                    timeout_next   = i_timeout_cycles;
                    idle_cnt_next  = '0;
`endif
                    state_next     = ST_RECV;
                end
            end

            ST_RECV: begin
                // A beat in the terminating cycle still counts.
                if (i_hsked) begin
                    beat_cnt_next = beat_inc;
                end
`ifdef RX_TIMEOUT_EN
                idle_cnt_next = i_hsked ? CNT_ZERO : idle_inc;
`endif
                if (i_abort) begin
                    status_next = STATUS_ABORT;
                    state_next  = ST_DONE;
                end else if (i_rx_done) begin
                    status_next = STATUS_OK;
                    state_next  = ST_DONE;
                end else if (limit_hit) begin
                    status_next = STATUS_LIMIT;
                    state_next  = ST_DONE;
                end else if (timeout_hit) begin
                    status_next = STATUS_TIMEOUT;
                    state_next  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_rx_rcving  = (state_reg == ST_RECV);
    assign o_busy       = (state_reg != ST_IDLE);
    assign o_done       = (state_reg == ST_DONE);
    assign o_status     = status_reg;
    assign o_beat_count = beat_cnt_reg;

endmodule

// File: tb/tb_rx_session_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_session_ctrl
//
// Directed bench for rx_session_ctrl. Each session that is expected to end
// pushes its {status, beat count} into a queue; a monitor running alongside
// the stimulus pops and compares whenever o_done is seen. Immediate checks
// cover reset, start latency, ignored requests and held results.
// ---------------------------------------------------------------------------
module tb_rx_session_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [1:0]   st;
        logic [W-1:0] cnt;
    } exp_t;

    logic         clk;
    logic         aresetn;
    logic         start;
    logic         abort;
    logic [W-1:0] max_beats;
`ifdef RX_TIMEOUT_EN
    logic [W-1:0] timeout_cycles;
`endif
    logic         hsked;
    logic         rx_done;
    logic         rx_rcving;
    logic         busy;
    logic         done;
    logic [1:0]   status;
    logic [W-1:0] beat_count;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    rx_session_ctrl #(.CNT_W(W)) dut (
        .s_axis_aclk      (clk),
        .s_axis_aresetn   (aresetn),
        .i_start          (start),
        .i_abort          (abort),
        .i_max_beats      (max_beats),
`ifdef RX_TIMEOUT_EN
        .i_timeout_cycles (timeout_cycles),
`endif
        .i_hsked          (hsked),
        .i_rx_done        (rx_done),
        .o_rx_rcving      (rx_rcving),
        .o_busy           (busy),
        .o_done           (done),
        .o_status         (status),
        .o_beat_count     (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] st, input logic [W-1:0] cnt);
        exp_t e;
        e.st  = st;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Issue a one-cycle start; returns one cycle later with the DUT in RECV.
    task automatic start_session(input logic [W-1:0] mb, input logic [W-1:0] to);
        start     = 1'b1;
        max_beats = mb;
`ifdef RX_TIMEOUT_EN
        timeout_cycles = to;
`else
        if (to != '0) $display("note: timeout value ignored in this build");
`endif
        tick();
        start = 1'b0;
    endtask

    // Bounded wait for o_done; returns the number of cycles waited.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (done !== 1'b1) chk("done_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_status", 32'(status), 32'(e.st));
                    chk("sb_beat_count", 32'(beat_count), 32'(e.cnt));
                    chk("sb_rcving_low_at_done", 32'(rx_rcving), 32'd0);
                end
            end
        end
    endtask

    task automatic stimulus();
        int n;
        aresetn   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        max_beats = '0;
`ifdef RX_TIMEOUT_EN
        timeout_cycles = '0;
`endif
        hsked     = 1'b0;
        rx_done   = 1'b0;
        #2;
        chk("rst_rcving", 32'(rx_rcving), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_count", 32'(beat_count), 32'd0);
        tick();
        aresetn = 1'b1;

        // Unlimited session: 5 beats, then done together with a 6th beat.
        start_session(4'd0, 4'd0);
        chk("start_rcving_next_cycle", 32'(rx_rcving), 32'd1);
        hsked = 1'b1;
        repeat (5) tick();
        push(2'b00, 4'd6);
        rx_done = 1'b1;
        tick();
        hsked   = 1'b0;
        rx_done = 1'b0;
        chk("done_one_cycle_later", 32'(done), 32'd1);
        chk("rcving_falls_with_done", 32'(rx_rcving), 32'd0);
        tick();
        chk("done_single_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("count_held", 32'(beat_count), 32'd6);

        // Beat limit 4 with continuous handshakes.
        start_session(4'd4, 4'd0);
        hsked = 1'b1;
        push(2'b01, 4'd4);
        wait_done(20, n);
        repeat (3) tick();
        hsked = 1'b0;
        chk("limit_later_beats_ignored", 32'(beat_count), 32'd4);
        chk("limit_status_held", 32'(status), 32'd1);

        // Abort, done and a beat in the same cycle: abort wins, beat counts.
        start_session(4'd0, 4'd0);
        hsked = 1'b1;
        repeat (2) tick();
        push(2'b11, 4'd3);
        abort   = 1'b1;
        rx_done = 1'b1;
        tick();
        abort   = 1'b0;
        rx_done = 1'b0;
        hsked   = 1'b0;
        tick();

        // Start while receiving and in DONE is ignored; abort in IDLE ignored.
        start_session(4'd0, 4'd0);
        hsked = 1'b1;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        hsked = 1'b0;
        chk("start_in_recv_ignored", 32'(beat_count), 32'd3);
        chk("still_rcving", 32'(rx_rcving), 32'd1);
        push(2'b00, 4'd3);
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_idle_ignored", 32'(busy), 32'd0);
        chk("abort_in_idle_status", 32'(status), 32'd0);

        // Beat counter saturates at 2^W-1.
        start_session(4'd0, 4'd0);
        hsked = 1'b1;
        repeat (17) tick();
        hsked = 1'b0;
        chk("count_saturates", 32'(beat_count), 32'd15);
        push(2'b00, 4'd15);
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();

        // Reset mid-session, then a fresh session counts from zero.
        start_session(4'd0, 4'd0);
        hsked = 1'b1;
        repeat (3) tick();
        hsked = 1'b0;
        chk("pre_reset_count", 32'(beat_count), 32'd3);
        aresetn = 1'b0;
        #1;
        chk("midrst_rcving", 32'(rx_rcving), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_status", 32'(status), 32'd0);
        chk("midrst_count", 32'(beat_count), 32'd0);
        tick();
        tick();
        aresetn = 1'b1;
        start_session(4'd0, 4'd0);
        chk("post_rst_start", 32'(rx_rcving), 32'd1);
        hsked = 1'b1;
        repeat (2) tick();
        hsked = 1'b0;
        chk("post_rst_count", 32'(beat_count), 32'd2);
        push(2'b00, 4'd2);
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();

`ifdef RX_TIMEOUT_EN
        // Timeout 10: done follows exactly 10 idle cycles after the last beat.
        start_session(4'd0, 4'd10);
        hsked = 1'b1;
        repeat (2) tick();
        hsked = 1'b0;
        push(2'b10, 4'd2);
        wait_done(50, n);
        chk("timeout_idle_cycles", 32'(n), 32'd10);
        tick();
`else
        // No timeout feature: a long idle stretch must not end the session.
        start_session(4'd0, 4'd10);
        hsked = 1'b1;
        repeat (2) tick();
        hsked = 1'b0;
        repeat (20) tick();
        chk("no_timeout_still_busy", 32'(busy), 32'd1);
        push(2'b00, 4'd2);
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
`endif

        repeat (3) tick();
        chk("all_sessions_completed", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fork
            monitor();
            stimulus();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
